pll_lock_manager: RTL and testbench
===================================

# pll_lock_manager

Parametrised PLL supervisor that runs in the reference-clock domain next to the board PLL wrapper. It owns the PLL `RESETB` pin: it resets the PLL, waits for lock with a timeout, retries a bounded number of times, and requires lock to be continuously stable before releasing the system reset. Lock loss during operation re-asserts system reset, counts the event, and restarts the sequence. It replaces direct tie-off of `RESETB` and raw use of `locked` as a reset.

## Interface
- `RST_CYCLES`, default 16: cycles `pll_resetb` is held low per attempt; must be ≥1.
- `LOCK_TIMEOUT`, default 12000: cycles allowed for lock per attempt, 1 ms at 12 MHz; must be ≥1.
- `STABLE_CYCLES`, default 1200: consecutive synced-lock cycles required before release; must be ≥1.
- `MAX_RETRIES`, default 3: retries after the first attempt before entering FAULT.
- `CNT_W`, default 8: width of `loss_count`.

- `clock_in`  in  1  reference clock; all logic runs on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears every register.
- `enable`  in  1  level; high starts or keeps the sequence running, low returns to IDLE.
- `pll_locked`  in  1  PLL `LOCK`; asynchronous, passed through a 2-FF synchroniser.
- `pll_resetb`  out  1  to PLL `RESETB`; low holds the PLL in reset.
- `sys_reset`  out  1  active-high reset for the downstream clock domain logic.
- `locked_stable`  out  1  high only in RUN.
- `fault`  out  1  high only in FAULT.
- `state`  out  3  current state encoding.
- `loss_count`  out  CNT_W  lock-loss events while in RUN; saturating.

## Operation
- States and encodings: IDLE=0, PLL_RST=1, WAIT_LOCK=2, SETTLE=3, RUN=4, FAULT=5. Codes 6 and 7 go to IDLE.
- All outputs are registered Moore decodes of the next state, so they change on the same edge as `state`.
  - `pll_resetb` is 1 only in WAIT_LOCK, SETTLE and RUN.
  - `sys_reset` is 0 only in RUN.
- Reset values:
  - state IDLE; `pll_resetb`=0, `sys_reset`=1, `locked_stable`=0, `fault`=0.
  - `loss_count`=0; internal retry counter=0, cycle timer=0, synchroniser flops=0.
- `lock_s` is the second synchroniser flop. Only `lock_s` is used by the FSM.
- Priority: when `enable`=0, every state goes to IDLE on the next edge. The retry counter and timer are cleared; `loss_count` is kept.
- Transitions. The timer clears on every state change and increments otherwise.
  - IDLE: `enable`=1 → PLL_RST.
  - PLL_RST: when timer==RST_CYCLES-1 → WAIT_LOCK.
  - WAIT_LOCK, evaluated in this order:
    - `lock_s`=1 → SETTLE.
    - Else if timer==LOCK_TIMEOUT-1:
      - retry counter==MAX_RETRIES → FAULT.
      - Otherwise increment the retry counter → PLL_RST.
  - SETTLE:
    - `lock_s`=0 → WAIT_LOCK. No retry increment; the timeout window restarts.
    - Else if timer==STABLE_CYCLES-1 → RUN, and the retry counter clears.
  - RUN: `lock_s`=0 → PLL_RST, and `loss_count` increments, saturating at 2^CNT_W-1.
  - FAULT: holds until `enable`=0, then → IDLE.
- Timer width is the clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES. The retry counter width is clog2(MAX_RETRIES+1).

## Timing
- Synchroniser latency: `lock_s` follows `pll_locked` after 2 edges.
- Enable start: `enable` sampled high at edge E.
  - State is PLL_RST after E.
  - `pll_resetb` rises after edge E+RST_CYCLES.
- Lock to release: call the first edge sampling `pll_locked`=1 edge 1.
  - SETTLE is entered after edge 3.
  - RUN, `sys_reset`=0 and `locked_stable`=1 after edge 3+STABLE_CYCLES.
- Lock loss to reset: call the first edge sampling `pll_locked`=0 in RUN edge 1.
  - After edge 3: `sys_reset`=1, `pll_resetb`=0, and `loss_count` is updated.
- Each failed attempt lasts RST_CYCLES+LOCK_TIMEOUT cycles. FAULT is entered after (MAX_RETRIES+1) attempts.
- Asynchronous `reset` forces the reset values immediately, mid-operation included. The first transition occurs on the first edge after deassertion.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, CNT_W=2.
- Normal start: `enable`=1, PLL model raises `pll_locked` 5 cycles after `pll_resetb` rises → `pll_resetb` is low for exactly 4 cycles; `sys_reset` falls and `state`=4 after edge 11 counted from the lock sample.
- No lock: `pll_locked` tied 0 → three `pll_resetb` low pulses of 4 cycles, 24 cycles apart; `fault`=1 and `state`=5 after 72 cycles; `enable`=0 → `state`=0 and `fault`=0 next edge.
- Lock loss ×4 in RUN, each followed by relock → each loss gives `sys_reset`=1 three edges after the drop; `loss_count` reads 1, 2, 3, 3 (saturates).
- SETTLE glitch: `pll_locked` low 3 cycles at settle count 5 → returns to WAIT_LOCK with no retry increment and `sys_reset` held 1; after relock, the full 8 settle cycles are required again.
- Asynchronous `reset` pulse mid-RUN between edges → `sys_reset`=1, `pll_resetb`=0, `loss_count`=0 and `state`=0 immediately; after release with `enable`=1, the sequence restarts.
- `enable` dropped during WAIT_LOCK at timer 10 → `state`=0 and `pll_resetb`=0 next edge; re-enable → retry counter starts from 0, shown by three full attempts before FAULT.

Source files
------------

// File: rtl/pll_lock_manager.sv
// PLL supervisor: drives RESETB, waits for lock with bounded retries, and only
// releases sys_reset once lock has been continuously stable.
module pll_lock_manager #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 12000,
   parameter int STABLE_CYCLES = 1200,
   parameter int MAX_RETRIES   = 3,
   parameter int CNT_W         = 8
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             pll_locked,
   output logic             pll_resetb,
   output logic             sys_reset,
   output logic             locked_stable,
   output logic             fault,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] loss_count
);

   localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_T = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
   localparam int RW    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [TW-1:0] T_RST    = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] T_LOCK   = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] T_STABLE = TW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] R_MAX    = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PLL_RST   = 3'd1,
      WAIT_LOCK = 3'd2,
      SETTLE    = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } state_t;

   state_t        cur, nxt;
   logic [TW-1:0] timer;
   logic [RW-1:0] retry;
   logic          lock_m, lock_s;

   assign state = cur;

   always_comb begin
      nxt = IDLE;
      case (cur)
         IDLE:      nxt = PLL_RST;
         PLL_RST:   nxt = (timer == T_RST) ? WAIT_LOCK : PLL_RST;
         WAIT_LOCK: begin
            if (lock_s)                nxt = SETTLE;
            else if (timer == T_LOCK)  nxt = (retry == R_MAX) ? FAULT : PLL_RST;
            else                       nxt = WAIT_LOCK;
         end
         SETTLE: begin
            if (!lock_s)                nxt = WAIT_LOCK;
            else if (timer == T_STABLE) nxt = RUN;
            else                        nxt = SETTLE;
         end
         RUN:       nxt = lock_s ? RUN : PLL_RST;
         FAULT:     nxt = FAULT;
         default:   nxt = IDLE;
      endcase
      if (!enable) nxt = IDLE;
   end

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         lock_m        <= 1'b0;
         lock_s        <= 1'b0;
         cur           <= IDLE;
         timer         <= '0;
         retry         <= '0;
         loss_count    <= '0;
         pll_resetb    <= 1'b0;
         sys_reset     <= 1'b1;
         locked_stable <= 1'b0;
         fault         <= 1'b0;
      end else begin
         lock_m <= pll_locked;
         lock_s <= lock_m;
         cur    <= nxt;
         timer  <= (!enable || nxt != cur) ? '0 : timer + TW'(1);

         if (!enable)
            retry <= '0;
         else if (cur == WAIT_LOCK && nxt == PLL_RST)
            retry <= retry + RW'(1);
         else if (cur == SETTLE && nxt == RUN)
            retry <= '0;

         // loss_count survives enable=0; only a true lock drop in RUN counts
         if (enable && cur == RUN && nxt == PLL_RST && loss_count != {CNT_W{1'b1}})
            loss_count <= loss_count + CNT_W'(1);

         pll_resetb    <= (nxt == WAIT_LOCK) || (nxt == SETTLE) || (nxt == RUN);
         sys_reset     <= (nxt != RUN);
         locked_stable <= (nxt == RUN);
         fault         <= (nxt == FAULT);
      end
   end

endmodule

// File: tb/tb_pll_lock_manager.sv
// Directed bench for pll_lock_manager with a queue scoreboard of expected
// output snapshots {state, sys_reset, pll_resetb, fault, locked_stable, loss_count}.
module tb_pll_lock_manager;

   logic       clk = 1'b0;
   logic       reset, enable, pll_locked;
   logic       pll_resetb, sys_reset, locked_stable, fault;
   logic [2:0] state;
   logic [1:0] loss_count;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string      tag;
      logic [8:0] val;
   } exp_t;

   exp_t sb[$];

   pll_lock_manager #(
      .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8),
      .MAX_RETRIES(2), .CNT_W(2)
   ) dut (
      .clock_in(clk), .reset(reset), .enable(enable), .pll_locked(pll_locked),
      .pll_resetb(pll_resetb), .sys_reset(sys_reset), .locked_stable(locked_stable),
      .fault(fault), .state(state), .loss_count(loss_count)
   );

   always #5 clk = ~clk;

   // push expectation, advance n edges (n==0: just settle 1 time unit), pop and compare
   task automatic chk(input string tag, input int n, input logic [2:0] st, input logic sr,
                      input logic rb, input logic flt, input logic ls, input logic [1:0] lc);
      exp_t e, p;
      logic [8:0] obs;
      e.tag = tag;
      e.val = {st, sr, rb, flt, ls, lc};
      sb.push_back(e);
      if (n == 0) #1;
      else repeat (n) begin @(posedge clk); #1; end
      p = sb.pop_front();
      obs = {state, sys_reset, pll_resetb, fault, locked_stable, loss_count};
      vectors++;
      assert (obs === p.val) else begin
         miscompares++;
         $error("FAIL %s: observed st=%0d sr=%b rb=%b f=%b ls=%b lc=%0d expected st=%0d sr=%b rb=%b f=%b ls=%b lc=%0d",
                p.tag, obs[8:6], obs[5], obs[4], obs[3], obs[2], obs[1:0],
                p.val[8:6], p.val[5], p.val[4], p.val[3], p.val[2], p.val[1:0]);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; pll_locked = 1'b0;
      chk("reset_vals", 0, 3'd0, 1, 0, 0, 0, 2'd0);
      tick(2);
      reset = 1'b0;

      // normal start
      enable = 1'b1;
      chk("start_rst", 1, 3'd1, 1, 0, 0, 0, 2'd0);
      chk("rst_hold", 3, 3'd1, 1, 0, 0, 0, 2'd0);
      chk("rb_rise", 1, 3'd2, 1, 1, 0, 0, 2'd0);
      tick(4);
      pll_locked = 1'b1;
      chk("sync_lat", 2, 3'd2, 1, 1, 0, 0, 2'd0);
      chk("settle_in", 1, 3'd3, 1, 1, 0, 0, 2'd0);
      chk("settle_end", 7, 3'd3, 1, 1, 0, 0, 2'd0);
      chk("run_in", 1, 3'd4, 0, 1, 0, 1, 2'd0);

      // four lock losses, count saturates at 3
      for (int i = 1; i <= 4; i++) begin
         pll_locked = 1'b0;
         chk($sformatf("loss%0d_pre", i), 2, 3'd4, 0, 1, 0, 1, 2'(i - 1 > 3 ? 3 : i - 1));
         chk($sformatf("loss%0d_rst", i), 1, 3'd1, 1, 0, 0, 0, 2'(i > 3 ? 3 : i));
         pll_locked = 1'b1;
         chk($sformatf("loss%0d_run", i), 13, 3'd4, 0, 1, 0, 1, 2'(i > 3 ? 3 : i));
      end

      // settle glitch
      enable = 1'b0;
      chk("dis_idle", 1, 3'd0, 1, 0, 0, 0, 2'd3);
      enable = 1'b1;
      chk("g_rst", 1, 3'd1, 1, 0, 0, 0, 2'd3);
      chk("g_wait", 4, 3'd2, 1, 1, 0, 0, 2'd3);
      chk("g_settle", 1, 3'd3, 1, 1, 0, 0, 2'd3);
      tick(5);
      pll_locked = 1'b0;
      chk("g_back", 3, 3'd2, 1, 1, 0, 0, 2'd3);
      pll_locked = 1'b1;
      chk("g_relock", 2, 3'd2, 1, 1, 0, 0, 2'd3);
      chk("g_settle2", 1, 3'd3, 1, 1, 0, 0, 2'd3);
      chk("g_full8", 7, 3'd3, 1, 1, 0, 0, 2'd3);
      chk("g_run", 1, 3'd4, 0, 1, 0, 1, 2'd3);

      // async reset mid-RUN, between edges
      #2 reset = 1'b1;
      chk("async_rst", 0, 3'd0, 1, 0, 0, 0, 2'd0);
      tick(1);
      pll_locked = 1'b0;
      reset = 1'b0;
      chk("restart", 1, 3'd1, 1, 0, 0, 0, 2'd0);

      // one timeout, then drop enable at timer 10 of the second wait
      chk("a1_wait", 4, 3'd2, 1, 1, 0, 0, 2'd0);
      chk("a1_tmo", 20, 3'd1, 1, 0, 0, 0, 2'd0);
      chk("a2_wait", 4, 3'd2, 1, 1, 0, 0, 2'd0);
      tick(10);
      enable = 1'b0;
      chk("en_drop", 1, 3'd0, 1, 0, 0, 0, 2'd0);

      // re-enable with no lock: three full attempts, then FAULT
      enable = 1'b1;
      chk("n_rst", 1, 3'd1, 1, 0, 0, 0, 2'd0);
      chk("n_rst_end", 3, 3'd1, 1, 0, 0, 0, 2'd0);
      chk("n_wait1", 1, 3'd2, 1, 1, 0, 0, 2'd0);
      chk("n_wait1_end", 19, 3'd2, 1, 1, 0, 0, 2'd0);
      chk("n_rst2", 1, 3'd1, 1, 0, 0, 0, 2'd0);
      chk("n_rst3", 24, 3'd1, 1, 0, 0, 0, 2'd0);
      chk("n_wait3_end", 23, 3'd2, 1, 1, 0, 0, 2'd0);
      chk("n_fault", 1, 3'd5, 1, 0, 1, 0, 2'd0);
      chk("fault_hold", 5, 3'd5, 1, 0, 1, 0, 2'd0);
      enable = 1'b0;
      chk("fault_clr", 1, 3'd0, 1, 0, 0, 0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
